// File: rtl/grey_frame_ctrl.sv
// grey_frame_ctrl
//   Frame sequencer for the 2x2 greyscale averaging datapath. Tracks the raw
//   pixel column/row within a frame opened by start-of-frame, drives the
//   line-buffer/tap shift enable, flags completed 2x2 windows together with
//   their output coordinates, and reports frame completion.
//
//   Optional feature macro: GREY_FRAME_ERR_EN
//     defined   : in_sof seen mid-frame sets sticky err and restarts the frame
//                 with that pixel as (0,0).
//     undefined : in_sof mid-frame is ignored (pixel counted normally), err=0.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   raw pixel present this cycle
//   in_sof     marks the in_valid pixel as frame pixel (0,0)
//   shift_en   combinational datapath/line-buffer shift enable
//   win_valid  registered, 2x2 window complete
//   out_x      registered greyscale x (col>>1 of window bottom-right pixel)
//   out_y      registered greyscale y (row>>1)
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
//   busy       frame in progress
//   err        sticky malformed-frame flag
module grey_frame_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          shift_en,
    output logic          win_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          frame_done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [CW-1:0] row, row_n;
    logic          win_n;
    logic          restart;

    assign shift_en   = in_valid && (state == ACTIVE || in_sof);
    assign busy       = (state == ACTIVE);
    assign frame_done = (state == DONE);

`ifdef GREY_FRAME_ERR_EN
    assign restart = in_sof;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (state == ACTIVE && shift_en && in_sof)
            err <= 1'b1;
    end
`else
    assign restart = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        win_n   = 1'b0;
        case (state)
            // In IDLE/DONE shift_en already implies in_sof: the accepted
            // pixel is (0,0), so counting resumes at column 1.
            IDLE: begin
                if (shift_en) begin
                    state_n = ACTIVE;
                    col_n   = CW'(1);
                    row_n   = '0;
                end
            end
            ACTIVE: begin
                if (shift_en) begin
                    if (restart) begin
                        col_n = CW'(1);
                        row_n = '0;
                    end else begin
                        win_n = col[0] && row[0];
                        if (col == COL_LAST && row == ROW_LAST) begin
                            state_n = DONE;
                            col_n   = '0;
                            row_n   = '0;
                        end else if (col == COL_LAST) begin
                            col_n = '0;
                            row_n = row + CW'(1);
                        end else begin
                            col_n = col + CW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (shift_en) begin
                    state_n = ACTIVE;
                    col_n   = CW'(1);
                    row_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            win_valid <= win_n;
            if (win_n) begin
                out_x <= col >> 1;
                out_y <= row >> 1;
            end
        end
    end

endmodule

// File: tb/tb_grey_frame_ctrl.sv
module tb_grey_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic          shift_en;
    logic          win_valid;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          frame_done;
    logic          busy;
    logic          err;

    grey_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .shift_en   (shift_en),
        .win_valid  (win_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    // reference model of the sequencer: 0 idle, 1 active, 2 done
    int   m_state;
    int   m_col;
    int   m_row;
    logic m_err;

    logic [2*CW-1:0] exp_q[$];
    logic [2*CW-1:0] obs_log[$];
    logic [2*CW-1:0] ref_wins[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_col   = 0;
        m_row   = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic post_check();
        logic [2*CW-1:0] e;
        if (exp_q.size() > 0) begin
            check("win_valid", {31'd0, win_valid}, 32'd1);
            e = exp_q.pop_front();
            check("out_xy", {10'd0, out_x, out_y}, {10'd0, e});
        end else begin
            check("win_valid", {31'd0, win_valid}, 32'd0);
        end
        if (win_valid) obs_log.push_back({out_x, out_y});
        if (frame_done) fd_cnt++;
        check("frame_done", {31'd0, frame_done}, {31'd0, (m_state == 2)});
        check("busy", {31'd0, busy}, {31'd0, (m_state == 1)});
        check("err", {31'd0, err}, {31'd0, m_err});
    endtask

    // one clock of stimulus: drive, check shift_en, update model, clock, check registered outputs
    task automatic step(input logic v, input logic s);
        logic exp_sh;
        in_valid = v;
        in_sof   = s;
        #1;
        exp_sh = v && (m_state == 1 || s);
        check("shift_en", {31'd0, shift_en}, {31'd0, exp_sh});
        if (exp_sh) begin
            if (m_state == 1) begin
`ifdef GREY_FRAME_ERR_EN
                if (s) begin
                    m_err = 1'b1;
                    m_col = 1;
                    m_row = 0;
                end else
`endif
                begin
                    if ((m_col % 2) == 1 && (m_row % 2) == 1)
                        exp_q.push_back({CW'(m_col / 2), CW'(m_row / 2)});
                    if (m_col == W - 1 && m_row == H - 1) begin
                        m_state = 2;
                        m_col   = 0;
                        m_row   = 0;
                    end else if (m_col == W - 1) begin
                        m_col = 0;
                        m_row = m_row + 1;
                    end else begin
                        m_col = m_col + 1;
                    end
                end
            end else begin
                m_state = 1;
                m_col   = 1;
                m_row   = 0;
            end
        end else if (m_state == 2) begin
            m_state = 0;
        end
        @(posedge clk);
        #1;
        post_check();
    endtask

    task automatic send_frame(input bit gaps);
        step(1'b1, 1'b1);
        for (int i = 1; i < W * H; i++) begin
            if (gaps) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic check_log(input string tag, input int frames);
        check({tag, "_count"}, obs_log.size(), 4 * frames);
        for (int f = 0; f < frames; f++)
            for (int k = 0; k < 4; k++)
                if (obs_log.size() > 4 * f + k)
                    check({tag, "_win"}, {10'd0, obs_log[4 * f + k]}, {10'd0, ref_wins[k]});
        obs_log.delete();
    endtask

    initial begin
        int n_tail;
        ref_wins[0] = {11'd0, 11'd0};
        ref_wins[1] = {11'd1, 11'd0};
        ref_wins[2] = {11'd0, 11'd1};
        ref_wins[3] = {11'd1, 11'd1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        model_reset();
        #3;
        check("rst_win_valid", {31'd0, win_valid}, 32'd0);
        check("rst_out_xy", {10'd0, out_x, out_y}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // continuous frame
        fd_cnt = 0;
        send_frame(1'b0);
        step(1'b0, 1'b0);
        check("cont_fd_cnt", fd_cnt, 1);
        check("cont_busy_after", {31'd0, busy}, 32'd0);
        check_log("cont", 1);

        // frame with a gap every other cycle
        fd_cnt = 0;
        send_frame(1'b1);
        step(1'b0, 1'b0);
        check("gap_fd_cnt", fd_cnt, 1);
        check_log("gap", 1);

        // back-to-back: second sof lands in the DONE cycle
        fd_cnt = 0;
        send_frame(1'b0);
        check("b2b_in_done", {31'd0, frame_done}, 32'd1);
        send_frame(1'b0);
        step(1'b0, 1'b0);
        check("b2b_fd_cnt", fd_cnt, 2);
        check_log("b2b", 2);

        // non-sof pixels in IDLE are dropped
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        send_frame(1'b0);
        step(1'b0, 1'b0);
        check_log("idle", 1);

        // asynchronous reset after pixel 9 of a frame
        step(1'b1, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_win_valid", {31'd0, win_valid}, 32'd0);
        check("arst_out_xy", {10'd0, out_x, out_y}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_frame_done", {31'd0, frame_done}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_shift_en", {31'd0, shift_en}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_log.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        fd_cnt = 0;
        send_frame(1'b0);
        step(1'b0, 1'b0);
        check("arst_fd_cnt", fd_cnt, 1);
        check_log("arst", 1);

        // sof arriving at pixel 6 of an active frame
        fd_cnt = 0;
        step(1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
`ifdef GREY_FRAME_ERR_EN
        n_tail = W * H - 1;
`else
        n_tail = W * H - 7;
`endif
        for (int i = 0; i < n_tail; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("sof_mid_fd_cnt", fd_cnt, 1);
`ifdef GREY_FRAME_ERR_EN
        check("sof_mid_err", {31'd0, err}, 32'd1);
        check("sof_mid_count", obs_log.size(), 5);
`else
        check("sof_mid_err", {31'd0, err}, 32'd0);
        check("sof_mid_count", obs_log.size(), 4);
`endif
        obs_log.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grey_frame_ctrl.md
# grey_frame_ctrl

Frame sequencer for the 2x2 greyscale averaging datapath. It tracks raw-pixel column/row across a frame delimited by start-of-frame, and generates the line-buffer/tap shift enable. It flags when a complete 2x2 Bayer window has been captured and supplies that window's output coordinates. It also reports frame completion and malformed frames; it sits between the camera pixel stream and the greyscale datapath.

## Interface
- IMG_W, 640, raw frame width in pixels; even, ≥2
- IMG_H, 480, raw frame height in lines; even, ≥2
- CW, 11, coordinate counter width; must hold IMG_W-1 and IMG_H-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  raw pixel present this cycle
- in_sof  in  1  qualifies in_valid pixel as frame pixel (0,0)
- shift_en  out  1  datapath/line-buffer shift enable (combinational)
- win_valid  out  1  registered; 2x2 window complete, datapath output valid
- out_x  out  CW  registered; greyscale x = col>>1 of window's bottom-right pixel
- out_y  out  CW  registered; greyscale y = row>>1
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted
- busy  out  1  state == ACTIVE
- err  out  1  sticky malformed-frame flag

## Operation
- States: IDLE, ACTIVE, DONE; rst → IDLE, col=0, row=0, all outputs 0.
- Accept = shift_en = in_valid && (state==ACTIVE || in_sof). Pixels with in_valid && !in_sof in IDLE/DONE are dropped (shift_en=0, no counter change).
- IDLE: accepted sof pixel is (0,0) → ACTIVE, col←1, row←0.
- ACTIVE: each accepted pixel at (col,row): if col==IMG_W-1 then col←0, row←row+1, else col←col+1. Pixel (IMG_W-1, IMG_H-1) → DONE, col←0, row←0. No accept: counters and state hold.
- win_valid←1 on the edge accepting a pixel with col odd and row odd; out_x←col>>1, out_y←row>>1 on that edge; otherwise win_valid←0, out_x/out_y hold.
- DONE: one cycle, frame_done=1 (Moore). Accepted sof pixel in DONE starts next frame directly (→ ACTIVE, col←1, row←0), with no lost pixel. Otherwise → IDLE.
- in_sof in ACTIVE: see Configuration.
- Counter arithmetic unsigned, CW bits; compare only on equality to IMG_W-1/IMG_H-1, no wrap beyond.
- err cleared only by rst.

## Timing
- shift_en: zero latency, combinational from in_valid, in_sof, state. The datapath registers taps on the same edge.
- win_valid/out_x/out_y: 1 cycle after the accepting edge of the window's bottom-right pixel. This aligns with the datapath's combinational average of its tap registers.
- frame_done: high the cycle after the last pixel is accepted, coincident with the final win_valid.
- Reset mid-frame: immediate return to IDLE, all outputs 0 asynchronously; the next frame requires a new sof.
- in_valid gaps of any length allowed; no timeout.

## Configuration
- GREY_FRAME_ERR_EN defined: in_sof with in_valid in ACTIVE sets err←1 and restarts the frame with that pixel as (0,0) (col←1, row←0). No frame_done for the aborted frame; no win_valid for that pixel.
- Undefined: in_sof in ACTIVE is ignored and the pixel is counted normally; err tied 0.

## Test plan
- IMG_W=4, IMG_H=4, sof then 16 continuous pixels → win_valid pulses after pixels 5, 7, 13, 15 with (out_x,out_y) = (0,0), (1,0), (0,1), (1,1). frame_done high for 1 cycle with the last win_valid; busy low afterwards.
- Same frame with in_valid low every other cycle → identical win_valid/coordinate sequence; counters hold during gaps; frame_done one cycle after pixel 15.
- Back-to-back: sof pixel presented in the DONE cycle → accepted, shift_en=1, busy next cycle; the second frame produces the same 4 windows.
- IDLE: 3 pixels with in_sof=0, then sof → first three have shift_en=0; the first window follows 5 pixels after sof.
- rst asserted after pixel 9 → all outputs 0 immediately. After release, non-sof pixels are ignored; a fresh sof frame completes normally.
- sof at pixel 6 of a frame: with GREY_FRAME_ERR_EN, err=1 and windows restart at (0,0) 5 pixels later, with no frame_done for the aborted frame. Without it, err=0 and the frame completes after pixel 15.
